vga_mem_fetch: RTL and testbench

VGA_MEM_FETCH -- requirements
Module: vga_mem_fetch

---
 rtl/vga_mem_fetch.sv | 140 ++++++++++++++
 tb/tb_vga_mem_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_fetch.sv
// Frame fetcher: streams DEPTH ROM words into a small FWFT buffer feeding a pixel consumer.
// Optional sticky underrun detection is built only when VGA_FETCH_UNDERRUN_EN is defined.
module vga_mem_fetch #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_in,
  output logic [$clog2(DEPTH)-1:0] rom_addr_out,
  output logic                     rom_rd_en_out,
  input  logic [WIDTH-1:0]         rom_dat_in,
  output logic [WIDTH-1:0]         pix_dat_out,
  output logic                     pix_valid_out,
  input  logic                     pix_ready_in,
  output logic                     busy_out,
  output logic                     underrun_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_addr;
  logic             r_pending;
  logic [PW:0]      r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic [CW-1:0]    w_occupancy;
  logic             w_last_addr;
  logic             w_rd_en;
  logic             w_valid;
  logic             w_bypass;
  logic             w_pop;
  logic             w_pop_mem;
  logic             w_push;
  logic [PW:0]      w_count_next;
  logic             w_busy;

  always_comb begin
    w_occupancy  = CW'(r_count) + CW'(r_pending);
    w_last_addr  = (r_addr == AW'(DEPTH - 1));
    w_rd_en      = (r_state == S_FETCH) && (w_occupancy < CW'(FIFO_DEPTH));
    // Returning ROM word is visible immediately when the buffer is empty
    w_bypass     = (r_count == '0) && r_pending;
    w_valid      = (r_count != '0) || r_pending;
    w_pop        = w_valid && pix_ready_in;
    w_pop_mem    = w_pop && (r_count != '0);
    w_push       = r_pending && !(w_bypass && w_pop);
    w_count_next = r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop_mem);
    w_busy       = (r_state != S_IDLE);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_state_next = S_FETCH;
      S_FETCH: if (w_rd_en && w_last_addr) w_state_next = S_DRAIN;
      // No reads are issued in DRAIN, so pending is zero after this edge
      S_DRAIN: if (w_count_next == '0) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_pending <= 1'b0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_rd_en;
      r_count   <= w_count_next;
      if ((r_state == S_IDLE) && start_in) begin
        r_addr <= '0;
      end else if (w_rd_en && !w_last_addr) begin
        r_addr <= r_addr + AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_mem) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rom_dat_in;
    end
  end

  always_comb begin
    pix_dat_out = '0;
    if (r_count != '0) begin
      pix_dat_out = r_mem[r_rd_ptr];
    end else if (r_pending) begin
      pix_dat_out = rom_dat_in;
    end
  end

  assign rom_addr_out  = r_addr;
  assign rom_rd_en_out = w_rd_en;
  assign pix_valid_out = w_valid;
  assign busy_out      = w_busy;

`ifdef VGA_FETCH_UNDERRUN_EN
  logic r_underrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else if ((r_state == S_IDLE) && start_in) begin
      r_underrun <= 1'b0;
    end else if (w_busy && pix_ready_in && (r_count == '0)) begin
      r_underrun <= 1'b1;
    end
  end

  assign underrun_out = r_underrun;
`else
  assign underrun_out = 1'b0;
`endif

endmodule

// File: tb/tb_vga_mem_fetch.sv
// Directed self-checking bench for vga_mem_fetch with a one-cycle-latency ROM model (mem[i] = 8'h10 + i).
module tb_vga_mem_fetch;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef VGA_FETCH_UNDERRUN_EN
  localparam logic EXP_UR = 1'b1;
`else
  localparam logic EXP_UR = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start_in = 1'b0;
  logic [$clog2(DEPTH)-1:0] rom_addr_out;
  logic                     rom_rd_en_out;
  logic [WIDTH-1:0]         rom_dat_in = '0;
  logic [WIDTH-1:0]         pix_dat_out;
  logic                     pix_valid_out;
  logic                     pix_ready_in = 1'b0;
  logic                     busy_out;
  logic                     underrun_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rom_rd_en_out) rom_dat_in <= 8'h10 + {4'h0, rom_addr_out};
  end

  vga_mem_fetch #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_in(start_in),
    .rom_addr_out(rom_addr_out),
    .rom_rd_en_out(rom_rd_en_out),
    .rom_dat_in(rom_dat_in),
    .pix_dat_out(pix_dat_out),
    .pix_valid_out(pix_valid_out),
    .pix_ready_in(pix_ready_in),
    .busy_out(busy_out),
    .underrun_out(underrun_out)
  );

  // One clock cycle: inputs change just after the edge, outputs are sampled mid-cycle.
  task automatic drive(input logic s, input logic r);
    @(posedge clk);
    #1;
    start_in     = s;
    pix_ready_in = r;
    @(negedge clk);
  endtask

  task automatic wait_idle(input logic r, output int n);
    n = 0;
    while (busy_out === 1'b1 && n < 200) begin
      drive(1'b0, r);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rom_rd_en_out !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rom_rd_en_out); end
    checks++; if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pix_valid_out); end
    checks++; if (pix_dat_out !== 8'h00) begin errors++; $display("FAIL reset_dat: got %h want 00", pix_dat_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    checks++; if (underrun_out !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun_out); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy_out); end
    $display("test_reset done");
  endtask

  task automatic test_stream;
    int n;
    int first_c;
    logic [7:0] exp;
    drive(1'b1, 1'b1);
    checks++; if (rom_rd_en_out !== 1'b0) begin errors++; $display("FAIL stream_c0_rd_en: got %b want 0", rom_rd_en_out); end
    drive(1'b0, 1'b1);
    checks++; if (rom_rd_en_out !== 1'b1 || rom_addr_out !== 4'd0) begin errors++; $display("FAIL stream_c1_read: got en=%b addr=%0d want en=1 addr=0", rom_rd_en_out, rom_addr_out); end
    checks++; if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL stream_c1_valid: got %b want 0", pix_valid_out); end
    n = 0;
    first_c = 0;
    for (int c = 2; c < 60 && n < 16; c++) begin
      drive(1'b0, 1'b1);
      if (pix_valid_out === 1'b1) begin
        exp = 8'h10 + 8'(n);
        checks++; if (pix_dat_out !== exp) begin errors++; $display("FAIL stream_pixel%0d: got %h want %h", n, pix_dat_out, exp); end
        checks++; if (c !== 2 + n) begin errors++; $display("FAIL stream_timing%0d: got cycle %0d want %0d", n, c, 2 + n); end
        if (n == 15) begin
          checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL stream_busy_last: got %b want 1", busy_out); end
        end
        $display("stream pixel %0d = %h at cycle %0d", n, pix_dat_out, c);
        n++;
      end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL stream_count: got %0d want 16", n); end
    drive(1'b0, 1'b1);
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL stream_busy_drop: got %b want 0", busy_out); end
    checks++; if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL stream_valid_end: got %b want 0", pix_valid_out); end
    checks++; if (rom_addr_out !== 4'd15) begin errors++; $display("FAIL stream_addr_end: got %0d want 15", rom_addr_out); end
  endtask

  task automatic test_backpressure;
    int reads;
    int n;
    int last_c;
    int w;
    logic [7:0] exp;
    drive(1'b1, 1'b0);
    reads = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0);
      if (rom_rd_en_out === 1'b1) begin
        checks++; if (rom_addr_out !== 4'(reads)) begin errors++; $display("FAIL bp_addr%0d: got %0d want %0d", reads, rom_addr_out, reads); end
        reads++;
      end
    end
    checks++; if (reads !== 4) begin errors++; $display("FAIL bp_reads: got %0d want 4", reads); end
    checks++; if (rom_rd_en_out !== 1'b0) begin errors++; $display("FAIL bp_stalled: got %b want 0", rom_rd_en_out); end
    checks++; if (pix_valid_out !== 1'b1 || pix_dat_out !== 8'h10) begin errors++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=10", pix_valid_out, pix_dat_out); end
    n = 0;
    last_c = -1;
    for (int c = 0; c < 60 && n < 16; c++) begin
      drive(1'b0, 1'b1);
      if (pix_valid_out === 1'b1) begin
        exp = 8'h10 + 8'(n);
        checks++; if (pix_dat_out !== exp) begin errors++; $display("FAIL bp_pixel%0d: got %h want %h", n, pix_dat_out, exp); end
        if (n > 0) begin
          checks++; if (c !== last_c + 1) begin errors++; $display("FAIL bp_gap%0d: got cycle %0d want %0d", n, c, last_c + 1); end
        end
        last_c = c;
        n++;
      end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL bp_count: got %0d want 16", n); end
    wait_idle(1'b1, w);
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy=%b want 0 after %0d cycles", busy_out, w); end
    $display("test_backpressure done");
  endtask

  task automatic test_toggle;
    int n;
    int reads;
    logic saw_drain;
    logic [7:0] exp;
    drive(1'b1, 1'b0);
    n = 0;
    reads = 0;
    saw_drain = 1'b0;
    for (int c = 0; c < 150; c++) begin
      drive(1'b0, (c % 2 == 0));
      if (rom_rd_en_out === 1'b1) begin
        checks++; if (rom_addr_out !== 4'(reads)) begin errors++; $display("FAIL tog_addr%0d: got %0d want %0d", reads, rom_addr_out, reads); end
        reads++;
      end
      if (reads == 16 && busy_out === 1'b1 && rom_rd_en_out === 1'b0) saw_drain = 1'b1;
      if (pix_valid_out === 1'b1 && pix_ready_in === 1'b1) begin
        exp = 8'h10 + 8'(n);
        checks++; if (pix_dat_out !== exp) begin errors++; $display("FAIL tog_pixel%0d: got %h want %h", n, pix_dat_out, exp); end
        n++;
      end
      if (busy_out !== 1'b1) break;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL tog_count: got %0d want 16", n); end
    checks++; if (reads !== 16) begin errors++; $display("FAIL tog_reads: got %0d want 16", reads); end
    checks++; if (rom_addr_out !== 4'd15) begin errors++; $display("FAIL tog_addr_end: got %0d want 15", rom_addr_out); end
    checks++; if (saw_drain !== 1'b1) begin errors++; $display("FAIL tog_drain: got %b want 1", saw_drain); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL tog_idle: got %b want 0", busy_out); end
    $display("test_toggle done");
  endtask

  task automatic test_ignored_start;
    int n;
    logic sent;
    logic [7:0] exp;
    drive(1'b1, 1'b1);
    n = 0;
    sent = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      start_in     = (rom_rd_en_out === 1'b1 && rom_addr_out === 4'd5 && !sent);
      pix_ready_in = 1'b1;
      if (start_in) sent = 1'b1;
      @(negedge clk);
      if (pix_valid_out === 1'b1) begin
        exp = 8'h10 + 8'(n);
        if (n >= 16) begin
          checks++; errors++; $display("FAIL ign_extra: got pixel %h want none", pix_dat_out);
        end else begin
          checks++; if (pix_dat_out !== exp) begin errors++; $display("FAIL ign_pixel%0d: got %h want %h", n, pix_dat_out, exp); end
        end
        n++;
      end
      if (busy_out !== 1'b1) break;
    end
    start_in = 1'b0;
    checks++; if (sent !== 1'b1) begin errors++; $display("FAIL ign_sent: got %b want 1", sent); end
    checks++; if (n !== 16) begin errors++; $display("FAIL ign_count: got %0d want 16", n); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL ign_idle: got %b want 0", busy_out); end
    $display("test_ignored_start done");
  endtask

  task automatic test_reset_mid;
    int n;
    int w;
    drive(1'b1, 1'b1);
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      drive(1'b0, 1'b1);
      if (pix_valid_out === 1'b1) n++;
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL rmid_pre: got %0d pixels want 6", n); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (rom_rd_en_out !== 1'b0) begin errors++; $display("FAIL rmid_rd_en: got %b want 0", rom_rd_en_out); end
    checks++; if (pix_valid_out !== 1'b0 || pix_dat_out !== 8'h00) begin errors++; $display("FAIL rmid_pix: got v=%b d=%h want v=0 d=00", pix_valid_out, pix_dat_out); end
    checks++; if (busy_out !== 1'b0 || underrun_out !== 1'b0) begin errors++; $display("FAIL rmid_flags: got busy=%b ur=%b want 0 0", busy_out, underrun_out); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b1);
    checks++; if (busy_out !== 1'b0 || pix_valid_out !== 1'b0) begin errors++; $display("FAIL rmid_wait: got busy=%b v=%b want 0 0", busy_out, pix_valid_out); end
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    checks++; if (pix_valid_out !== 1'b1 || pix_dat_out !== 8'h10) begin errors++; $display("FAIL rmid_restart: got v=%b d=%h want v=1 d=10", pix_valid_out, pix_dat_out); end
    wait_idle(1'b1, w);
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rmid_idle: got busy=%b want 0 after %0d cycles", busy_out, w); end
    $display("test_reset_mid done");
  endtask

  task automatic test_underrun;
    int w;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    checks++; if (underrun_out !== EXP_UR) begin errors++; $display("FAIL ur_set: got %b want %b", underrun_out, EXP_UR); end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (underrun_out !== EXP_UR) begin errors++; $display("FAIL ur_hold: got %b want %b", underrun_out, EXP_UR); end
    wait_idle(1'b1, w);
    checks++; if (underrun_out !== EXP_UR || busy_out !== 1'b0) begin errors++; $display("FAIL ur_idle_hold: got ur=%b busy=%b want %b 0", underrun_out, busy_out, EXP_UR); end
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (underrun_out !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b want 0", underrun_out); end
    wait_idle(1'b1, w);
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL ur_final_idle: got %b want 0", busy_out); end
    $display("test_underrun done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_ignored_start();
    test_reset_mid();
    test_underrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
